// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared types and constants for the ready/valid FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Default payload width of the FIFO
    localparam int RV_DATA_WIDTH = 64;

    // Occupancy state of the FIFO
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } rv_fifo_state_t;

    // Next value of a power-of-two ring pointer; plain wrap-around of the
    // binary value visits every slot exactly once.
    function automatic logic [31:0] rv_ptr_inc(input logic [31:0] ptr,
                                               input int unsigned depth);
        logic [31:0] nxt;
        nxt = ptr + 32'd1;
        if (nxt == depth) begin
            nxt = 32'd0;
        end
        return nxt;
    endfunction

endpackage : rv_pkg
`default_nettype wire

// File: rtl/reg_def.sv
`default_nettype none
// ============================================================================
// Module      : reg_def
// Description : Generic enabled register with synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_def #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // Capture d_i when enabled; clear to zero while reset is low
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : reg_def
`default_nettype wire

// File: rtl/rv_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv_fifo
// Description : Ready/valid synchronous FIFO with first-word fall-through
//               from registered storage, occupancy count and a one-cycle
//               transfer-done pulse following each pop.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_fifo
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH = RV_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    rv_fifo_state_t        state_q,  state_d;

    logic                  push;
    logic                  pop;
    logic                  tx_done_w;

    // Handshake flags depend only on registered state, never on the
    // partner's valid/ready, so no combinational path crosses the FIFO.
    assign s_ready = (state_q != FULL);
    assign m_valid = (state_q != EMPTY);
    assign m_data  = mem_q[rd_ptr_q];
    assign count   = count_q;

    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    // Write the incoming word into the slot addressed by the write pointer;
    // contents are intentionally left untouched by reset.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Pointer next-state: advance on the matching transfer, wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
    end

    // Occupancy FSM next-state and count update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            EMPTY: begin
                // Nothing to pop here; a push always leaves at least one
                // free slot because DEPTH is two or more.
                if (push) begin
                    count_d = c_CNT_ONE;
                    state_d = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop) begin
                    count_d = count_q + c_CNT_ONE;
                    if (count_q + c_CNT_ONE == c_CNT_FULL) begin
                        state_d = FULL;
                    end
                end else if (pop && !push) begin
                    count_d = count_q - c_CNT_ONE;
                    if (count_q == c_CNT_ONE) begin
                        state_d = EMPTY;
                    end
                end
            end
            FULL: begin
                // s_ready is low, so only a pop can happen
                if (pop) begin
                    count_d = count_q - c_CNT_ONE;
                    state_d = PARTIAL;
                end
            end
            default: begin
                state_d = EMPTY;
                count_d = '0;
            end
        endcase
    end

    // State, count and pointer registers; reset overrides any transfer
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Transfer-done pulse: registered copy of the pop strobe, so
    // back-to-back pops produce a continuous high level.
    // ------------------------------------------------------------------
    reg_def #(
        .WIDTH (1)
    ) u_tx_done_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .d_i   (pop),
        .q_o   (tx_done_w)
    );

    assign tx_done = tx_done_w;

endmodule : rv_fifo
`default_nettype wire

// File: tb/tb_rv_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_fifo
// Description : Directed, scoreboard-checked bench for rv_fifo
//               (DATA_WIDTH=64, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_fifo;

    localparam int DW = 64;
    localparam int DP = 4;

    logic          clk;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [2:0]    count;
    logic          tx_done;

    rv_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: words accepted by the FIFO, oldest first
    logic [DW-1:0] q_model [$];
    logic          exp_tx;
    int            n_assert;
    int            n_fail;
    bit            chk_en;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model (mid-cycle), then advance
    // the model across the rising edge. Returns at the following falling edge.
    task automatic tick();
        bit push_m;
        bit pop_m;
        if (chk_en) begin
            chk("s_ready", DW'(s_ready), DW'(q_model.size() < DP));
            chk("m_valid", DW'(m_valid), DW'(q_model.size() > 0));
            chk("count",   DW'(count),   DW'(q_model.size()));
            chk("tx_done", DW'(tx_done), DW'(exp_tx));
            if (q_model.size() > 0) begin
                chk("m_data", m_data, q_model[0]);
            end
        end
        push_m = s_valid && (q_model.size() < DP);
        pop_m  = m_ready && (q_model.size() > 0);
        @(posedge clk);
        if (!reset) begin
            q_model.delete();
            exp_tx = 1'b0;
        end else begin
            if (pop_m) begin
                void'(q_model.pop_front());
            end
            if (push_m) begin
                q_model.push_back(s_data);
            end
            exp_tx = pop_m;
        end
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        exp_tx   = 1'b0;
        reset    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;
        @(negedge clk);

        // Reset low for two cycles, outputs undefined before the first edge
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b1;
        chk("rst_s_ready", DW'(s_ready), DW'(1'b1));
        chk("rst_m_valid", DW'(m_valid), DW'(1'b0));
        chk("rst_count",   DW'(count),   DW'(0));
        chk("rst_tx_done", DW'(tx_done), DW'(1'b0));
        tick();

        // Fill with A1..A4, downstream stalled
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'hA0 + i);
            tick();
        end
        chk("full_count",   DW'(count),   DW'(4));
        chk("full_s_ready", DW'(s_ready), DW'(1'b0));
        // Fifth word must be ignored
        s_data = DW'(8'hA5);
        tick();
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("head_A1", m_data, DW'(8'hA1));
        for (int i = 0; i < 4; i++) tick();
        m_ready = 1'b0;
        chk("tx_after_last_pop", DW'(tx_done), DW'(1'b1));
        tick();
        chk("drained_m_valid", DW'(m_valid), DW'(1'b0));
        tick();

        // 1-cycle latency: push 0x55 into EMPTY
        s_valid = 1'b1;
        s_data  = DW'(8'h55);
        chk("lat_m_valid_push_cycle", DW'(m_valid), DW'(1'b0));
        tick();
        s_valid = 1'b0;
        chk("lat_m_valid_after", DW'(m_valid), DW'(1'b1));
        chk("lat_m_data",        m_data,       DW'(8'h55));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Prime count=2, then stream 10 cycles with push and pop both active
        s_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data = DW'(16'hB000 + i);
            tick();
        end
        m_ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            s_data = DW'(16'hB000 + i);
            tick();
        end
        chk("stream_count", DW'(count), DW'(2));
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        m_ready = 1'b0;

        // FULL with push and pop requested: pop only
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = DW'(16'hC000 + i);
            tick();
        end
        s_data  = DW'(16'hC0FF);
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        chk("full_pop_count",   DW'(count),   DW'(3));
        chk("full_pop_s_ready", DW'(s_ready), DW'(1'b1));
        tick();

        // count=3, reset with push and pop active
        s_valid = 1'b1;
        s_data  = DW'(16'hD000);
        m_ready = 1'b1;
        reset   = 1'b0;
        tick();
        reset   = 1'b1;
        s_valid = 1'b0;
        chk("rst_mid_count",   DW'(count),   DW'(0));
        chk("rst_mid_m_valid", DW'(m_valid), DW'(1'b0));
        for (int i = 0; i < 3; i++) tick();
        m_ready = 1'b0;

        // Short randomised traffic against the scoreboard
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = {$urandom, $urandom};
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule : tb_rv_fifo
`default_nettype wire
